// File: rtl/jtcontra_layermix.sv
// Layer priority mixer with CPU-accessible 16-bit palette and a 3-stage,
// pixel-enable-qualified colour pipeline with aligned blanking outputs.
module jtcontra_layermix #(
    parameter  int unsigned LAYERS = 2,
    parameter  int unsigned PXLW   = 7,
    parameter  int unsigned TRANSW = 4,
    localparam int unsigned LYW    = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int unsigned IDXW   = LYW + PXLW,
    localparam int unsigned AW     = IDXW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   cpu_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [LAYERS*PXLW-1:0] pxl_in,
    input  logic [LAYERS-1:0]      layer_en,
    input  logic [1:0]             prio_mode,
    input  logic                   pal_cs,
    input  logic                   cpu_rnw,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    output logic [4:0]             red,
    output logic [4:0]             green,
    output logic [4:0]             blue,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly
);

    localparam int unsigned PALN = 1 << IDXW;

    logic [PXLW-1:0] lyr_pxl [LAYERS];
    logic [LAYERS-1:0] opaque;
    logic [IDXW-1:0] mix_idx;

    logic [15:0]     pal [PALN];
    logic [IDXW-1:0] pal_wa;

    logic [IDXW-1:0] idx_s1;
    logic [14:0]     word_s2;
    logic            hb_s1, vb_s1, hb_s2, vb_s2;

    assign pal_wa = cpu_addr[AW-1:1];

    // Per-layer pixel slices and transparency test
    for (genvar k = 0; k < LAYERS; k++) begin : g_layer
        assign lyr_pxl[k] = pxl_in[k*PXLW +: PXLW];
        assign opaque[k]  = layer_en[k] && (lyr_pxl[k][TRANSW-1:0] != '0);
    end

    // Layer number at depth position pos (0 = frontmost) for the given mode
    function automatic logic [LYW-1:0] layer_at(input int unsigned pos,
                                                input logic [1:0] mode,
                                                input logic l0_front);
        int unsigned k;
        case (mode)
            2'd1:    k = LAYERS - 1 - pos;
            2'd2:    k = l0_front ? pos : ((pos == LAYERS - 1) ? 32'd0 : pos + 1);
            default: k = pos;
        endcase
        return LYW'(k);
    endfunction

    // Walk back to front so the frontmost opaque layer is the last to win
    always_comb begin
        logic [LYW-1:0] lyr;
        mix_idx = '0;
        lyr     = '0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            lyr = layer_at(LAYERS - 1 - i, prio_mode, lyr_pxl[0][PXLW-1]);
            if (opaque[lyr]) mix_idx = {lyr, lyr_pxl[lyr]};
        end
    end

    // Palette storage is deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_rnw && cpu_cen) begin
            if (cpu_addr[0]) pal[pal_wa][15:8] <= cpu_dout;
            else             pal[pal_wa][7:0]  <= cpu_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_dout <= 8'd0;
        end else if (pal_cs && cpu_rnw) begin
            pal_dout <= cpu_addr[0] ? pal[pal_wa][15:8] : pal[pal_wa][7:0];
        end
    end

    // Video pipeline; the S2 read samples the palette before any same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_s1   <= '0;
            hb_s1    <= 1'b0;
            vb_s1    <= 1'b0;
            word_s2  <= 15'd0;
            hb_s2    <= 1'b0;
            vb_s2    <= 1'b0;
            red      <= 5'd0;
            green    <= 5'd0;
            blue     <= 5'd0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            idx_s1   <= mix_idx;
            hb_s1    <= LHBL;
            vb_s1    <= LVBL;
            word_s2  <= pal[idx_s1][14:0];
            hb_s2    <= hb_s1;
            vb_s2    <= vb_s1;
            LHBL_dly <= hb_s2;
            LVBL_dly <= vb_s2;
            if (hb_s2 && vb_s2) begin
                red   <= word_s2[4:0];
                green <= word_s2[9:5];
                blue  <= word_s2[14:10];
            end else begin
                red   <= 5'd0;
                green <= 5'd0;
                blue  <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_jtcontra_layermix.sv
// Directed self-checking bench for jtcontra_layermix (LAYERS=2, PXLW=7).
module tb_jtcontra_layermix;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pxl_cen, cpu_cen, LHBL, LVBL;
    logic [13:0] pxl_in;
    logic [1:0]  layer_en, prio_mode;
    logic        pal_cs, cpu_rnw;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_dout, pal_dout;
    logic [4:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly;
    logic [14:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign rgb = {red, green, blue};

    jtcontra_layermix #(.LAYERS(2), .PXLW(7), .TRANSW(4)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen),
        .LHBL(LHBL), .LVBL(LVBL), .pxl_in(pxl_in), .layer_en(layer_en),
        .prio_mode(prio_mode), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
        .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dout = d; pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1;
        tick();
        pal_cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic cpu_rd(input logic [8:0] a, output logic [7:0] d);
        cpu_addr = a; pal_cs = 1'b1; cpu_rnw = 1'b1;
        tick();
        d = pal_dout;
        pal_cs = 1'b0;
    endtask

    task automatic pal_word(input logic [7:0] idx, input logic [15:0] w);
        cpu_wr({idx, 1'b0}, w[7:0]);
        cpu_wr({idx, 1'b1}, w[15:8]);
    endtask

    task automatic set_px(input logic [6:0] l0, input logic [6:0] l1,
                          input logic [1:0] en, input logic [1:0] mode);
        pxl_in = {l1, l0}; layer_en = en; prio_mode = mode;
    endtask

    task automatic run(input int n);
        pxl_cen = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (rgb !== 15'd0) begin n_fail++; $display("FAIL reset_rgb: got %h want 0", rgb); end
        n_checks++;
        if (pal_dout !== 8'd0) begin n_fail++; $display("FAIL reset_pal_dout: got %h want 0", pal_dout); end
        n_checks++;
        if ({LHBL_dly, LVBL_dly} !== 2'b00) begin
            n_fail++; $display("FAIL reset_blank: got %b want 00", {LHBL_dly, LVBL_dly});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_rw();
        logic [7:0] d;
        pxl_cen = 1'b0;
        cpu_wr({8'h01, 1'b0}, 8'h1F);
        cpu_wr({8'h01, 1'b1}, 8'h7C);
        // a write without cpu_cen must be ignored
        cpu_addr = {8'h01, 1'b1}; cpu_dout = 8'hAA; pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b0;
        tick();
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b1;
        cpu_addr = {8'h01, 1'b1}; pal_cs = 1'b1; cpu_rnw = 1'b1;
        n_checks++;
        if (pal_dout !== 8'h00) begin n_fail++; $display("FAIL rd_latency: got %h want 00 before clk", pal_dout); end
        tick();
        d = pal_dout; pal_cs = 1'b0;
        n_checks++;
        if (d !== 8'h7C) begin n_fail++; $display("FAIL rd_byte3: got %h want 7c", d); end
        cpu_rd({8'h01, 1'b0}, d);
        n_checks++;
        if (d !== 8'h1F) begin n_fail++; $display("FAIL rd_byte2: got %h want 1f", d); end
        set_px(7'h01, 7'h00, 2'b11, 2'd0);
        run(2);
        n_checks++;
        if ({rgb, LHBL_dly} !== 16'd0) begin
            n_fail++; $display("FAIL refill_2: got rgb=%h hb=%b want 0", rgb, LHBL_dly);
        end
        run(1);
        n_checks++;
        if (rgb !== {5'd31, 5'd0, 5'd31}) begin n_fail++; $display("FAIL pal1_rgb: got %h want %h", rgb, {5'd31, 5'd0, 5'd31}); end
        n_checks++;
        if ({LHBL_dly, LVBL_dly} !== 2'b11) begin
            n_fail++; $display("FAIL refill_3_blank: got %b want 11", {LHBL_dly, LVBL_dly});
        end
    endtask

    task automatic test_priority();
        pxl_cen = 1'b0;
        pal_word(8'h05, {1'b0, 5'd1, 5'd2, 5'd3});
        pal_word(8'h93, {1'b0, 5'd4, 5'd5, 5'd6});
        pal_word(8'h45, {1'b0, 5'd7, 5'd8, 5'd9});
        set_px(7'h05, 7'h13, 2'b11, 2'd0); run(3);
        n_checks++;
        if (rgb !== {5'd3, 5'd2, 5'd1}) begin n_fail++; $display("FAIL mode0: got %h want %h", rgb, {5'd3, 5'd2, 5'd1}); end
        set_px(7'h05, 7'h13, 2'b11, 2'd1); run(3);
        n_checks++;
        if (rgb !== {5'd6, 5'd5, 5'd4}) begin n_fail++; $display("FAIL mode1: got %h want %h", rgb, {5'd6, 5'd5, 5'd4}); end
        set_px(7'h05, 7'h13, 2'b11, 2'd2); run(3);
        n_checks++;
        if (rgb !== {5'd6, 5'd5, 5'd4}) begin n_fail++; $display("FAIL mode2_msb0: got %h want %h", rgb, {5'd6, 5'd5, 5'd4}); end
        set_px(7'h45, 7'h13, 2'b11, 2'd2); run(3);
        n_checks++;
        if (rgb !== {5'd9, 5'd8, 5'd7}) begin n_fail++; $display("FAIL mode2_msb1: got %h want %h", rgb, {5'd9, 5'd8, 5'd7}); end
        set_px(7'h05, 7'h10, 2'b11, 2'd2); run(3);
        n_checks++;
        if (rgb !== {5'd3, 5'd2, 5'd1}) begin n_fail++; $display("FAIL mode2_l1_clear: got %h want %h", rgb, {5'd3, 5'd2, 5'd1}); end
        set_px(7'h05, 7'h13, 2'b11, 2'd3); run(3);
        n_checks++;
        if (rgb !== {5'd3, 5'd2, 5'd1}) begin n_fail++; $display("FAIL mode3: got %h want %h", rgb, {5'd3, 5'd2, 5'd1}); end
        set_px(7'h10, 7'h13, 2'b11, 2'd0); run(3);
        n_checks++;
        if (rgb !== {5'd6, 5'd5, 5'd4}) begin n_fail++; $display("FAIL mode0_l0_clear: got %h want %h", rgb, {5'd6, 5'd5, 5'd4}); end
        set_px(7'h05, 7'h13, 2'b01, 2'd1); run(3);
        n_checks++;
        if (rgb !== {5'd3, 5'd2, 5'd1}) begin n_fail++; $display("FAIL mode1_l1_off: got %h want %h", rgb, {5'd3, 5'd2, 5'd1}); end
    endtask

    task automatic test_transparent();
        pxl_cen = 1'b0;
        pal_word(8'h00, {1'b0, 5'd10, 5'd11, 5'd12});
        set_px(7'h10, 7'h10, 2'b11, 2'd0); run(3);
        n_checks++;
        if (rgb !== {5'd12, 5'd11, 5'd10}) begin n_fail++; $display("FAIL all_clear: got %h want %h", rgb, {5'd12, 5'd11, 5'd10}); end
        set_px(7'h05, 7'h13, 2'b00, 2'd0); run(3);
        n_checks++;
        if (rgb !== {5'd12, 5'd11, 5'd10}) begin n_fail++; $display("FAIL all_off: got %h want %h", rgb, {5'd12, 5'd11, 5'd10}); end
        set_px(7'h05, 7'h13, 2'b10, 2'd0); run(3);
        n_checks++;
        if (rgb !== {5'd6, 5'd5, 5'd4}) begin n_fail++; $display("FAIL l0_off: got %h want %h", rgb, {5'd6, 5'd5, 5'd4}); end
    endtask

    task automatic test_blanking();
        set_px(7'h05, 7'h13, 2'b11, 2'd0); run(3);
        LHBL = 1'b0; run(1);
        LHBL = 1'b1; run(1);
        n_checks++;
        if (LHBL_dly !== 1'b1) begin n_fail++; $display("FAIL hb_early: got %b want 1", LHBL_dly); end
        run(1);
        n_checks++;
        if ({LHBL_dly, rgb} !== 16'd0) begin n_fail++; $display("FAIL hb_pulse: got hb=%b rgb=%h want 0", LHBL_dly, rgb); end
        run(1);
        n_checks++;
        if ({LHBL_dly, rgb} !== {1'b1, 5'd3, 5'd2, 5'd1}) begin
            n_fail++; $display("FAIL hb_after: got hb=%b rgb=%h want 1/%h", LHBL_dly, rgb, {5'd3, 5'd2, 5'd1});
        end
        LVBL = 1'b0; run(1);
        LVBL = 1'b1; run(2);
        n_checks++;
        if ({LVBL_dly, rgb} !== 16'd0) begin n_fail++; $display("FAIL vb_pulse: got vb=%b rgb=%h want 0", LVBL_dly, rgb); end
        run(1);
    endtask

    task automatic test_hold();
        logic [7:0] d;
        pxl_cen = 1'b0;
        set_px(7'h05, 7'h13, 2'b11, 2'd1);
        repeat (4) tick();
        n_checks++;
        if (rgb !== {5'd3, 5'd2, 5'd1}) begin n_fail++; $display("FAIL hold_rgb: got %h want %h", rgb, {5'd3, 5'd2, 5'd1}); end
        cpu_rd({8'h05, 1'b0}, d);
        n_checks++;
        if (d !== 8'h43) begin n_fail++; $display("FAIL hold_cpu_rd: got %h want 43", d); end
        run(3);
        n_checks++;
        if (rgb !== {5'd6, 5'd5, 5'd4}) begin n_fail++; $display("FAIL hold_resume: got %h want %h", rgb, {5'd6, 5'd5, 5'd4}); end
    endtask

    task automatic test_collision();
        // pipeline is steady on word 0x93 (0x10A6); rewrite its low byte during S2 reads
        pxl_cen = 1'b1;
        cpu_wr({8'h93, 1'b0}, 8'h1F);
        run(1);
        n_checks++;
        if (rgb !== {5'd6, 5'd5, 5'd4}) begin n_fail++; $display("FAIL collide_old: got %h want %h", rgb, {5'd6, 5'd5, 5'd4}); end
        run(1);
        n_checks++;
        if (rgb !== {5'd31, 5'd0, 5'd4}) begin n_fail++; $display("FAIL collide_new: got %h want %h", rgb, {5'd31, 5'd0, 5'd4}); end
    endtask

    task automatic test_reset_midline();
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            pxl_cen = ~pxl_cen;
            tick();
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rgb, LHBL_dly, LVBL_dly, pal_dout} !== 25'd0) begin
            n_fail++; $display("FAIL midline_rst: got rgb=%h hb=%b vb=%b dout=%h want 0", rgb, LHBL_dly, LVBL_dly, pal_dout);
        end
        for (int i = 0; i < 3; i++) begin
            pxl_cen = ~pxl_cen;
            tick();
        end
        rst_n = 1'b1;
        pxl_cen = 1'b0;
        cpu_rd({8'h05, 1'b1}, d);
        n_checks++;
        if (d !== 8'h04) begin n_fail++; $display("FAIL retain_05hi: got %h want 04", d); end
        cpu_rd({8'h93, 1'b0}, d);
        n_checks++;
        if (d !== 8'h1F) begin n_fail++; $display("FAIL retain_93lo: got %h want 1f", d); end
        set_px(7'h05, 7'h13, 2'b11, 2'd0);
        run(2);
        n_checks++;
        if (rgb !== 15'd0) begin n_fail++; $display("FAIL post_rst_2: got %h want 0", rgb); end
        run(1);
        n_checks++;
        if (rgb !== {5'd3, 5'd2, 5'd1}) begin n_fail++; $display("FAIL post_rst_3: got %h want %h", rgb, {5'd3, 5'd2, 5'd1}); end
    endtask

    initial begin
        pxl_cen = 1'b0; cpu_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
        pxl_in = '0; layer_en = 2'b11; prio_mode = 2'd0;
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = '0;
        #2;
        test_reset();
        test_cpu_rw();
        test_priority();
        test_transparent();
        test_blanking();
        test_hold();
        test_collision();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
